// File: rtl/snes_cpu_bus_master.sv
// Initiator-side SNES cartridge-slot bus model: turns request/response transactions
// into timed CPU bus cycles (address, strobes, ROM select, data bus) plus periodic DRAM refresh.
module snes_cpu_bus_master #(
  parameter int FAST_LEN       = 6,
  parameter int SLOW_LEN       = 8,
  parameter int XSLOW_LEN      = 12,
  parameter int REFRESH_PERIOD = 1364,
  parameter int REFRESH_START  = 538,
  parameter int REFRESH_LEN    = 40
) (
  input  logic        mck,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        fast_rom,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [23:0] ca,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        cpurd_n,
  output logic        cpuwr_n,
  output logic        romsel_n,
  output logic        refresh
);

  localparam int MAX_LEN = (XSLOW_LEN > REFRESH_LEN) ? XSLOW_LEN : REFRESH_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int RW      = $clog2(REFRESH_PERIOD);

  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CYCLE,
    S_RESP,
    S_REFRESH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          is_write_q, is_write_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pending_q, pending_d;
  logic          refresh_hit;
  logic          accept;
  logic [CW-1:0] acc_len;

  logic [23:0] ca_d;
  logic [7:0]  d_out_d, rsp_rdata_d;
  logic        d_oe_d, cpurd_n_d, cpuwr_n_d, romsel_n_d, refresh_d;
  logic        req_ready_d, rsp_valid_d;

  // ROM select: banks $40-$FF with bit 6 set decode everywhere except WRAM banks $7E/$7F;
  // the remaining banks decode only the upper half of the offset space.
  function automatic logic rom_decode_n(input logic [23:0] addr);
    if (addr[22]) return (addr[23:17] == 7'h3F);
    return ~addr[15];
  endfunction

  // Extra-slow I/O window $4000-$41FF in system banks.
  function automatic logic is_xslow(input logic [23:0] addr);
    return ~addr[22] && (addr[15:9] == 7'b0100000);
  endfunction

  // Free-running scanline counter, independent of bus activity.
  assign refresh_hit = (rcnt_q == RW'(REFRESH_START));
  assign rcnt_d      = (rcnt_q == RW'(REFRESH_PERIOD - 1)) ? '0 : rcnt_q + RW'(1);

  assign accept = req_valid && req_ready && ((state_q == S_IDLE) || (state_q == S_RESP));

  always_comb begin
    acc_len = CW'(SLOW_LEN);
    if (is_xslow(req_addr)) begin
      acc_len = CW'(XSLOW_LEN);
    end else if (req_addr[23] && !rom_decode_n(req_addr) && fast_rom) begin
      acc_len = CW'(FAST_LEN);
    end
  end

  always_comb begin
    // NOTE: every next-value signal is defaulted before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    is_write_d  = is_write_q;
    pending_d   = pending_q | refresh_hit;
    ca_d        = ca;
    d_out_d     = d_out;
    d_oe_d      = d_oe;
    cpurd_n_d   = cpurd_n;
    cpuwr_n_d   = cpuwr_n;
    romsel_n_d  = romsel_n;
    refresh_d   = refresh;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;

    if (accept) begin
      ca_d        = req_addr;
      romsel_n_d  = rom_decode_n(req_addr);
      if (req_write) d_out_d = req_wdata;
      is_write_d  = req_write;
      len_d       = acc_len;
      cnt_d       = '0;
      req_ready_d = 1'b0;
      state_d     = S_CYCLE;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (pending_q) begin
            state_d     = S_REFRESH;
            cnt_d       = '0;
            refresh_d   = 1'b1;
            req_ready_d = 1'b0;
          end else begin
            state_d     = S_IDLE;
            req_ready_d = ~pending_d;
          end
        end
        S_CYCLE: begin
          if (cnt_q == len_q - CNT_ONE) begin
            if (!is_write_q) rsp_rdata_d = d_in;
            cpurd_n_d   = 1'b1;
            cpuwr_n_d   = 1'b1;
            d_oe_d      = 1'b0;
            romsel_n_d  = 1'b1;
            rsp_valid_d = 1'b1;
            req_ready_d = ~pending_d;
            state_d     = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            // Registered outputs: decisions taken at cnt k become visible at cnt k+1.
            if ((cnt_q == '0) && is_write_q) d_oe_d = 1'b1;
            if (cnt_q == CNT_ONE) begin
              cpurd_n_d = is_write_q;
              cpuwr_n_d = ~is_write_q;
            end
          end
        end
        S_REFRESH: begin
          if (cnt_q == REFRESH_LAST) begin
            refresh_d   = 1'b0;
            pending_d   = refresh_hit;
            req_ready_d = ~refresh_hit;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values computed above regardless of statement order.
  always_ff @(posedge mck or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      is_write_q <= 1'b0;
      rcnt_q     <= '0;
      pending_q  <= 1'b0;
      ca         <= '0;
      d_out      <= '0;
      d_oe       <= 1'b0;
      cpurd_n    <= 1'b1;
      cpuwr_n    <= 1'b1;
      romsel_n   <= 1'b1;
      refresh    <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      is_write_q <= is_write_d;
      rcnt_q     <= rcnt_d;
      pending_q  <= pending_d;
      ca         <= ca_d;
      d_out      <= d_out_d;
      d_oe       <= d_oe_d;
      cpurd_n    <= cpurd_n_d;
      cpuwr_n    <= cpuwr_n_d;
      romsel_n   <= romsel_n_d;
      refresh    <= refresh_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_snes_cpu_bus_master.sv
// Self-checking bench for snes_cpu_bus_master: per-cycle strobe tracing plus a read-data
// scoreboard (expected rsp_rdata pushed at request time, popped on rsp_valid).
module tb_snes_cpu_bus_master;

  logic        mck = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        fast_rom = 1'b0;
  logic [7:0]  d_in = '0;
  logic        req_ready, rsp_valid, d_oe, cpurd_n, cpuwr_n, romsel_n, refresh;
  logic [7:0]  rsp_rdata, d_out;
  logic [23:0] ca;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'h00;
  int tb_rcnt;

  typedef struct {
    int         len;
    int         rd_first;
    int         rd_cnt;
    int         wr_first;
    int         wr_cnt;
    int         oe_first;
    int         oe_cnt;
    int         rom_cnt;
    bit         ca_ok;
    bit         dout_ok;
    bit         rel_ok;
    logic [7:0] rdata;
  } obs_t;

  snes_cpu_bus_master dut (
    .mck(mck), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .fast_rom(fast_rom),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ca(ca), .d_out(d_out), .d_oe(d_oe),
    .d_in(d_in), .cpurd_n(cpurd_n), .cpuwr_n(cpuwr_n), .romsel_n(romsel_n), .refresh(refresh)
  );

  always #5 mck = ~mck;

  // Reference scanline counter: value after each edge, cleared by reset.
  always @(posedge mck or negedge reset_n) begin
    if (!reset_n) tb_rcnt <= 0;
    else tb_rcnt <= (tb_rcnt == 1363) ? 0 : tb_rcnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic push_exp(input logic wr, input logic [7:0] din);
    exp_q.push_back(wr ? last_rd : din);
    if (!wr) last_rd = din;
  endtask

  task automatic pop_exp(output logic [7:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
  endtask

  // Drives one request from a negedge and traces the bus every negedge until rsp_valid.
  // Sample index i equals the visible cnt; o.len is the index where rsp_valid appears.
  task automatic run_txn(input logic wr, input logic [23:0] addr, input logic [7:0] wd,
                         input logic fr, input logic [7:0] din, output obs_t o);
    int w;
    o.len = -1; o.rd_first = -1; o.rd_cnt = 0; o.wr_first = -1; o.wr_cnt = 0;
    o.oe_first = -1; o.oe_cnt = 0; o.rom_cnt = 0; o.ca_ok = 1'b1; o.dout_ok = 1'b1;
    o.rel_ok = 1'b0; o.rdata = 8'h00;
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin @(negedge mck); w++; end
    if (req_ready === 1'b1) begin
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      fast_rom = fr; d_in = din;
      @(negedge mck);
      req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (rsp_valid === 1'b1) begin
          o.len = i;
          o.rdata = rsp_rdata;
          o.rel_ok = (cpurd_n === 1'b1) && (cpuwr_n === 1'b1) && (romsel_n === 1'b1) && (d_oe === 1'b0);
          break;
        end
        if (cpurd_n === 1'b0) begin if (o.rd_first < 0) o.rd_first = i; o.rd_cnt++; end
        if (cpuwr_n === 1'b0) begin if (o.wr_first < 0) o.wr_first = i; o.wr_cnt++; end
        if (d_oe === 1'b1) begin
          if (o.oe_first < 0) o.oe_first = i;
          o.oe_cnt++;
          if (d_out !== wd) o.dout_ok = 1'b0;
        end
        if (romsel_n === 1'b0) o.rom_cnt++;
        if (ca !== addr) o.ca_ok = 1'b0;
        @(negedge mck);
      end
    end
  endtask

  task automatic test_reset();
    logic [46:0] got, want;
    reset_n = 1'b0;
    repeat (3) @(negedge mck);
    got  = {ca, d_out, d_oe, cpurd_n, cpuwr_n, romsel_n, refresh, req_ready, rsp_valid, rsp_rdata};
    want = {24'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0};
    compared++; if (got !== want) begin mismatched++; $display("FAIL reset_values: got %h want %h", got, want); end
    reset_n = 1'b1;
    #1;
    compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
    @(negedge mck);
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
  endtask

  task automatic test_slow_read();
    obs_t o;
    logic [7:0] e;
    push_exp(1'b0, 8'hA5);
    run_txn(1'b0, 24'h008000, 8'h00, 1'b0, 8'hA5, o);
    pop_exp(e);
    compared++; if (o.len !== 8) begin mismatched++; $display("FAIL slow_len: got %0d want 8", o.len); end
    compared++; if (o.rd_first !== 2 || o.rd_cnt !== 6) begin mismatched++; $display("FAIL slow_rd_strobe: got first %0d cnt %0d want 2 6", o.rd_first, o.rd_cnt); end
    compared++; if (o.rom_cnt !== 8) begin mismatched++; $display("FAIL slow_romsel: got %0d low cycles want 8", o.rom_cnt); end
    compared++; if (!o.ca_ok) begin mismatched++; $display("FAIL slow_ca: got mismatch want 008000 throughout"); end
    compared++; if (o.wr_cnt !== 0 || o.oe_cnt !== 0) begin mismatched++; $display("FAIL slow_no_write: got wr %0d oe %0d want 0 0", o.wr_cnt, o.oe_cnt); end
    compared++; if (o.rdata !== e) begin mismatched++; $display("FAIL slow_rdata: got %h want %h", o.rdata, e); end
    compared++; if (!o.rel_ok) begin mismatched++; $display("FAIL slow_release: got strobes active want released at completion"); end
    @(negedge mck);
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL slow_rsp_pulse: got %b want 0", rsp_valid); end
    compared++; if (ca !== 24'h008000) begin mismatched++; $display("FAIL slow_ca_hold: got %h want 008000", ca); end
  endtask

  task automatic test_decode();
    logic [23:0] addrs[10] = '{24'h808000, 24'h808000, 24'hC00000, 24'h7E0000, 24'hFE1234,
                               24'h004200, 24'h0041FF, 24'h804000, 24'h404000, 24'h7FFFFF};
    logic        frs[10]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int          lens[10]  = '{6, 8, 6, 8, 6, 8, 12, 12, 8, 8};
    bit          lows[10]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    obs_t o;
    logic [7:0] e, din;
    for (int i = 0; i < 10; i++) begin
      din = 8'h10 + 8'(i);
      push_exp(1'b0, din);
      run_txn(1'b0, addrs[i], 8'h00, frs[i], din, o);
      pop_exp(e);
      compared++; if (o.len !== lens[i]) begin mismatched++; $display("FAIL decode_len[%0d]: got %0d want %0d", i, o.len, lens[i]); end
      compared++; if (o.rom_cnt !== (lows[i] ? lens[i] : 0)) begin mismatched++; $display("FAIL decode_romsel[%0d]: got %0d want %0d", i, o.rom_cnt, lows[i] ? lens[i] : 0); end
      compared++; if (o.rd_cnt !== lens[i] - 2 || o.rd_first !== 2) begin mismatched++; $display("FAIL decode_rd[%0d]: got first %0d cnt %0d want 2 %0d", i, o.rd_first, o.rd_cnt, lens[i] - 2); end
      compared++; if (o.rdata !== e) begin mismatched++; $display("FAIL decode_rdata[%0d]: got %h want %h", i, o.rdata, e); end
    end
  endtask

  task automatic test_xslow_write();
    obs_t o;
    logic [7:0] e;
    push_exp(1'b1, 8'h00);
    run_txn(1'b1, 24'h004016, 8'h01, 1'b1, 8'hEE, o);
    pop_exp(e);
    compared++; if (o.len !== 12) begin mismatched++; $display("FAIL wr_len: got %0d want 12", o.len); end
    compared++; if (o.rom_cnt !== 0) begin mismatched++; $display("FAIL wr_romsel: got %0d low cycles want 0", o.rom_cnt); end
    compared++; if (o.wr_first !== 2 || o.wr_cnt !== 10) begin mismatched++; $display("FAIL wr_strobe: got first %0d cnt %0d want 2 10", o.wr_first, o.wr_cnt); end
    compared++; if (o.oe_first !== 1 || o.oe_cnt !== 11) begin mismatched++; $display("FAIL wr_oe: got first %0d cnt %0d want 1 11", o.oe_first, o.oe_cnt); end
    compared++; if (!o.dout_ok) begin mismatched++; $display("FAIL wr_dout: got wrong drive want 01"); end
    compared++; if (o.rd_cnt !== 0) begin mismatched++; $display("FAIL wr_no_read: got %0d want 0", o.rd_cnt); end
    compared++; if (o.rdata !== e) begin mismatched++; $display("FAIL wr_rdata_hold: got %h want %h", o.rdata, e); end
    compared++; if (!o.rel_ok) begin mismatched++; $display("FAIL wr_release: got strobes active want released"); end
  endtask

  task automatic test_back_to_back();
    int first_idx, second_idx, w;
    logic [7:0] e;
    first_idx = -1; second_idx = -1; w = 0;
    while (req_ready !== 1'b1 && w < 100) begin @(negedge mck); w++; end
    push_exp(1'b0, 8'h3C);
    push_exp(1'b0, 8'hC3);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h008000; fast_rom = 1'b0; d_in = 8'h3C;
    @(negedge mck);
    req_addr = 24'h008001;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid === 1'b1) begin
        pop_exp(e);
        if (first_idx < 0) begin
          first_idx = i;
          compared++; if (rsp_rdata !== e) begin mismatched++; $display("FAIL b2b_rdata0: got %h want %h", rsp_rdata, e); end
          d_in = 8'hC3;
        end else begin
          second_idx = i;
          compared++; if (rsp_rdata !== e) begin mismatched++; $display("FAIL b2b_rdata1: got %h want %h", rsp_rdata, e); end
          break;
        end
      end
      @(negedge mck);
    end
    req_valid = 1'b0;
    compared++; if (first_idx !== 8) begin mismatched++; $display("FAIL b2b_first: got %0d want 8", first_idx); end
    compared++; if (second_idx !== 17) begin mismatched++; $display("FAIL b2b_second: got %0d want 17", second_idx); end
    @(negedge mck);
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    logic [7:0] e;
    int w, seen;
    w = 0; seen = 0;
    while (req_ready !== 1'b1 && w < 100) begin @(negedge mck); w++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h008000; req_wdata = 8'h5A;
    @(negedge mck);
    req_valid = 1'b0;
    repeat (4) @(negedge mck);
    compared++; if (cpuwr_n !== 1'b0 || d_oe !== 1'b1) begin mismatched++; $display("FAIL midwr_active: got wr_n %b oe %b want 0 1", cpuwr_n, d_oe); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if ({cpuwr_n, cpurd_n, romsel_n, d_oe} !== 4'b1110) begin mismatched++; $display("FAIL midwr_release: got %b want 1110", {cpuwr_n, cpurd_n, romsel_n, d_oe}); end
    exp_q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge mck);
    reset_n = 1'b1;
    repeat (4) begin @(negedge mck); if (rsp_valid !== 1'b0) seen++; end
    compared++; if (seen !== 0) begin mismatched++; $display("FAIL midwr_no_rsp: got %0d pulses want 0", seen); end
    push_exp(1'b0, 8'h77);
    run_txn(1'b0, 24'h009000, 8'h00, 1'b0, 8'h77, o);
    pop_exp(e);
    compared++; if (o.len !== 8 || o.rd_cnt !== 6) begin mismatched++; $display("FAIL midwr_next_read: got len %0d rd %0d want 8 6", o.len, o.rd_cnt); end
    compared++; if (o.rdata !== e) begin mismatched++; $display("FAIL midwr_rdata: got %h want %h", o.rdata, e); end
  endtask

  task automatic test_refresh();
    obs_t o;
    logic [7:0] e;
    int w, n, bad;
    reset_n = 1'b0;
    exp_q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge mck);
    reset_n = 1'b1;
    w = 0;
    while (tb_rcnt != 536 && w < 3000) begin @(negedge mck); w++; end
    compared++; if (tb_rcnt != 536 || req_ready !== 1'b1) begin mismatched++; $display("FAIL ref_setup: got cnt %0d ready %b want 536 1", tb_rcnt, req_ready); end
    push_exp(1'b0, 8'h96);
    run_txn(1'b0, 24'h008000, 8'h00, 1'b0, 8'h96, o);
    pop_exp(e);
    compared++; if (o.len !== 8 || o.rdata !== e) begin mismatched++; $display("FAIL ref_read: got len %0d data %h want 8 %h", o.len, o.rdata, e); end
    @(negedge mck);
    compared++; if (refresh !== 1'b1 || rsp_valid !== 1'b0 || tb_rcnt != 546) begin mismatched++; $display("FAIL ref_start: got refresh %b rsp %b cnt %0d want 1 0 546", refresh, rsp_valid, tb_rcnt); end
    n = 0; bad = 0;
    while (refresh === 1'b1 && n < 100) begin
      if (req_ready !== 1'b0) bad++;
      n++;
      @(negedge mck);
    end
    compared++; if (n !== 40) begin mismatched++; $display("FAIL ref_len: got %0d want 40", n); end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL ref_ready_low: got %0d ready cycles want 0", bad); end
    compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL ref_ready_after: got %b want 1", req_ready); end
    w = 0;
    while (refresh !== 1'b1 && w < 2000) begin @(negedge mck); w++; end
    compared++; if (refresh !== 1'b1 || tb_rcnt != 540) begin mismatched++; $display("FAIL ref_period: got refresh %b cnt %0d want 1 540", refresh, tb_rcnt); end
  endtask

  initial begin
    test_reset();
    test_slow_read();
    test_decode();
    test_xslow_write();
    test_back_to_back();
    test_reset_mid_write();
    test_refresh();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
